// File: rtl/stream_recv_ctrl.sv
// Byte-stream receiver: captures the fixed-length image header, then removes
// FF00 byte stuffing from entropy data until EOI (FF D9) or an illegal marker.
module stream_recv_ctrl #(
    parameter int MARKER_BYTE_NUM = -1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [7:0]                         i_data,
    input  logic                               i_valid,
    input  logic                               i_wait,
    output logic                               o_ready,
    output logic [0:MARKER_BYTE_NUM-1][7:0]    o_marker_array,
    output logic                               o_marker_valid,
    output logic                               o_header_err,
    output logic [7:0]                         o_data,
    output logic                               o_valid,
    output logic                               o_data_end,
    output logic                               o_err
);

    // state   | meaning
    // MARKER  | collecting header bytes into o_marker_array
    // DATA    | passing entropy bytes through
    // FF_SEEN | previous data byte was FF; next byte selects stuff/EOI/fill/error

    typedef enum logic [1:0] {
        MARKER  = 2'd0,
        DATA    = 2'd1,
        FF_SEEN = 2'd2
    } state_t;

    localparam int CNT_W = (MARKER_BYTE_NUM > 2) ? $clog2(MARKER_BYTE_NUM) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MARKER_BYTE_NUM - 1);

    generate
        if (MARKER_BYTE_NUM < 2) begin : g_param_check
            $error("stream_recv_ctrl: MARKER_BYTE_NUM must be >= 2");
        end
    endgenerate

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [7:0]         hdr_b1;
    logic               hdr_bad;

    assign o_ready = ~i_wait;

    // With a two-byte header, byte1 is still on the input when the check is made.
    assign hdr_b1  = (MARKER_BYTE_NUM == 2) ? i_data : o_marker_array[1];
    assign hdr_bad = (o_marker_array[0] != 8'hFF) || (hdr_b1 != 8'hD8);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= MARKER;
            count          <= '0;
            o_marker_array <= '0;
            o_marker_valid <= 1'b0;
            o_header_err   <= 1'b0;
            o_data         <= 8'h00;
            o_valid        <= 1'b0;
            o_data_end     <= 1'b0;
            o_err          <= 1'b0;
        end else if (!i_wait) begin
            // a stall freezes everything, so pulses stretch until i_wait falls
            o_marker_valid <= 1'b0;
            o_header_err   <= 1'b0;
            o_data_end     <= 1'b0;
            o_err          <= 1'b0;
            o_valid        <= 1'b0;
            case (state)
                MARKER: begin
                    if (i_valid) begin
                        o_marker_array[count] <= i_data;
                        if (count == LAST_IDX) begin
                            count          <= '0;
                            state          <= DATA;
                            o_marker_valid <= 1'b1;
                            o_header_err   <= hdr_bad;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (i_valid) begin
                        if (i_data == 8'hFF) begin
                            state <= FF_SEEN;
                        end else begin
                            o_data  <= i_data;
                            o_valid <= 1'b1;
                        end
                    end
                end
                FF_SEEN: begin
                    if (i_valid) begin
                        case (i_data)
                            8'h00: begin
                                o_data  <= 8'hFF;
                                o_valid <= 1'b1;
                                state   <= DATA;
                            end
                            8'hD9: begin
                                o_data_end <= 1'b1;
                                state      <= MARKER;
                            end
                            8'hFF: state <= FF_SEEN;
                            default: begin
                                o_err <= 1'b1;
                                state <= MARKER;
                            end
                        endcase
                    end
                end
                default: state <= MARKER;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_recv_ctrl.sv
// Scoreboard bench for stream_recv_ctrl: stimulus pushes expected output events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_stream_recv_ctrl;

    localparam int N = 4;
    localparam int K_DATA = 0;
    localparam int K_HDR  = 1;
    localparam int K_END  = 2;
    localparam int K_ERR  = 3;

    logic                  clk;
    logic                  rst;
    logic [7:0]            i_data;
    logic                  i_valid;
    logic                  i_wait;
    logic                  o_ready;
    logic [0:N-1][7:0]     o_marker_array;
    logic                  o_marker_valid;
    logic                  o_header_err;
    logic [7:0]            o_data;
    logic                  o_valid;
    logic                  o_data_end;
    logic                  o_err;

    stream_recv_ctrl #(.MARKER_BYTE_NUM(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_data         (i_data),
        .i_valid        (i_valid),
        .i_wait         (i_wait),
        .o_ready        (o_ready),
        .o_marker_array (o_marker_array),
        .o_marker_valid (o_marker_valid),
        .o_header_err   (o_header_err),
        .o_data         (o_data),
        .o_valid        (o_valid),
        .o_data_end     (o_data_end),
        .o_err          (o_err)
    );

    typedef struct {
        int          kind;
        logic [7:0]  d;
        logic [31:0] hdr;
        logic        herr;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_data(input logic [7:0] b);
        ev_t e;
        e.kind = K_DATA; e.d = b; e.hdr = '0; e.herr = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_hdr(input logic [31:0] h, input logic herr);
        ev_t e;
        e.kind = K_HDR; e.d = 8'h00; e.hdr = h; e.herr = herr;
        exp_q.push_back(e);
    endtask

    task automatic push_kind(input int k);
        ev_t e;
        e.kind = k; e.d = 8'h00; e.hdr = '0; e.herr = 1'b0;
        exp_q.push_back(e);
    endtask

    // one byte accepted at the next rising edge
    task automatic send(input logic [7:0] b);
        i_valid = 1'b1;
        i_data  = b;
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [31:0] h);
        for (int i = 0; i < 4; i++) send(h[31-8*i -: 8]);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_arr"},  o_marker_array, 32'h0);
        chk({tag, "_data"}, {24'h0, o_data}, 32'h0);
        chk({tag, "_pulses"},
            {26'h0, o_valid, o_marker_valid, o_header_err, o_data_end, o_err, 1'b0}, 32'h0);
    endtask

    // monitor: one output event at most per cycle, consumed only when not stalled
    always @(negedge clk) begin
        int  n;
        int  kind;
        ev_t e;
        if (!rst && !i_wait) begin
            n = int'(o_valid) + int'(o_marker_valid) + int'(o_data_end) + int'(o_err);
            if (o_header_err && !o_marker_valid) begin
                checks++; errors++;
                $display("FAIL header_err_alone: got 1 expected 0");
            end
            if (n > 1) begin
                checks++; errors++;
                $display("FAIL exclusive_outputs: got %0d events expected at most 1", n);
            end else if (n == 1) begin
                kind = o_valid ? K_DATA : o_marker_valid ? K_HDR : o_data_end ? K_END : K_ERR;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_event: got kind %0d expected none", kind);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", kind, e.kind);
                    if (e.kind == K_DATA && kind == K_DATA)
                        chk("o_data", {24'h0, o_data}, {24'h0, e.d});
                    if (e.kind == K_HDR && kind == K_HDR) begin
                        chk("o_marker_array", o_marker_array, e.hdr);
                        chk("o_header_err", {31'h0, o_header_err}, {31'h0, e.herr});
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; i_data = 8'h00; i_valid = 1'b0; i_wait = 1'b0;
        #2;
        chk_all_zero("reset");
        chk("reset_ready", {31'h0, o_ready}, 32'h1);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        // basic image, then back-to-back image with stuffing
        push_hdr(32'hFFD8FFE0, 1'b0); send_hdr(32'hFFD8FFE0);
        push_data(8'h12); send(8'h12);
        push_data(8'h34); send(8'h34);
        send(8'hFF); push_kind(K_END); send(8'hD9);
        push_hdr(32'hFFD8FFE1, 1'b0); send_hdr(32'hFFD8FFE1);
        send(8'hFF); push_data(8'hFF); send(8'h00);
        push_data(8'h7F); send(8'h7F);
        send(8'hFF); push_data(8'hFF); send(8'h00);
        send(8'hFF); push_kind(K_END); send(8'hD9);

        // header errors, illegal marker, fill bytes
        push_hdr(32'hFFD90001, 1'b1); send_hdr(32'hFFD90001);
        push_data(8'h42); send(8'h42);
        send(8'hFF); push_kind(K_ERR); send(8'h55);
        push_hdr(32'hAAD80102, 1'b1); send_hdr(32'hAAD80102);
        send(8'hFF); send(8'hFF); push_kind(K_END); send(8'hD9);
        @(posedge clk); #1;

        // stall while o_data = 34 is presented
        push_hdr(32'hFFD8FFE0, 1'b0); send_hdr(32'hFFD8FFE0);
        push_data(8'h12); send(8'h12);
        push_data(8'h34); send(8'h34);
        i_wait = 1'b1; i_valid = 1'b1; i_data = 8'h56;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("stall_ready", {31'h0, o_ready}, 32'h0);
            chk("stall_valid", {31'h0, o_valid}, 32'h1);
            chk("stall_data", {24'h0, o_data}, 32'h34);
            @(posedge clk); #1;
        end
        i_wait = 1'b0;
        push_data(8'h56);
        @(posedge clk); #1;
        i_valid = 1'b0;
        send(8'hFF); push_kind(K_END); send(8'hD9);

        // reset mid-data and mid-header
        push_hdr(32'hFFD8FFE0, 1'b0); send_hdr(32'hFFD8FFE0);
        push_data(8'h12); send(8'h12);
        push_data(8'h34); send(8'h34);
        @(posedge clk); #1;
        rst = 1'b1; #1;
        chk_all_zero("mid_data_rst");
        @(posedge clk); #1; rst = 1'b0;
        send(8'hFF); send(8'hD8);
        rst = 1'b1; #1;
        chk_all_zero("mid_hdr_rst");
        @(posedge clk); #1; rst = 1'b0;
        push_hdr(32'hFFD8FFE0, 1'b0); send_hdr(32'hFFD8FFE0);
        push_data(8'h77); send(8'h77);
        send(8'hFF); push_kind(K_END); send(8'hD9);

        repeat (4) @(posedge clk);
        #1;
        chk("events_left", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
